// File: rtl/vga_capture_if.sv
// Video-input / captured-pixel bundle for vga_capture.
// FRAME_CRC is present only when VGA_CAPTURE_CRC_EN is defined.
interface vga_capture_if;
   logic        PCK_EN;
   logic        HS;
   logic        VS;
   logic [5:0]  R;
   logic [5:0]  G;
   logic [5:0]  B;
   logic        PIX_VALID;
   logic [9:0]  PIX_X;
   logic [9:0]  PIX_Y;
   logic [17:0] PIX_DATA;
   logic        LINE_END;
   logic        FRAME_END;
   logic        LOCKED;
   logic        ERR;
`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] FRAME_CRC;
`endif

   // Video source and pixel sink side.
   modport master (
      output PCK_EN, HS, VS, R, G, B,
      input  PIX_VALID, PIX_X, PIX_Y, PIX_DATA, LINE_END, FRAME_END, LOCKED, ERR
`ifdef VGA_CAPTURE_CRC_EN
      , input FRAME_CRC
`endif
   );

   modport slave (
      input  PCK_EN, HS, VS, R, G, B,
      output PIX_VALID, PIX_X, PIX_Y, PIX_DATA, LINE_END, FRAME_END, LOCKED, ERR
`ifdef VGA_CAPTURE_CRC_EN
      , output FRAME_CRC
`endif
   );
endinterface

// File: rtl/vga_capture.sv
// VGA timing verifier and active-area pixel capture. Locks after one clean measured frame.
// Optional per-frame CRC-16-CCITT on FRAME_CRC when VGA_CAPTURE_CRC_EN is defined.
module vga_capture #(
   parameter int unsigned HTOTAL = 800,
   parameter int unsigned VTOTAL = 525,
   parameter int unsigned HSTART = 144,
   parameter int unsigned VSTART = 35,
   parameter int unsigned HWIDTH = 640,
   parameter int unsigned VWIDTH = 480
) (
   input logic          CLK,
   input logic          RST,
   vga_capture_if.slave vid
);

   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   localparam logic [9:0] H_LAST  = 10'(HTOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(VTOTAL - 1);
   localparam logic [9:0] H_LO    = 10'(HSTART);
   localparam logic [9:0] H_END   = 10'(HSTART + HWIDTH - 1);
   localparam logic [9:0] V_LO    = 10'(VSTART);
   localparam logic [9:0] V_END   = 10'(VSTART + VWIDTH - 1);
   localparam logic [9:0] CNT_MAX = 10'h3FF;

   logic        hs_s, vs_s, hs_p, vs_p;
   logic [17:0] rgb_s;
   logic        stb_q;
   logic [9:0]  hc_q, hc_d, vc_q, vc_d;
   logic [1:0]  state_q, state_d;
   logic        line_bad_q, line_bad_d;
   logic        err_q, err_d;
   logic        locked_q;
   logic        pix_valid_q, line_end_q, frame_end_q;
   logic [9:0]  pix_x_q, pix_y_q;
   logic [17:0] pix_data_q;
   logic        hs_fall, vs_fall, h_bad, v_bad;
   logic        pix_hit, line_last, frame_last;

   // Counters and FSM advance one CLK after the strobe, once the sample is registered.
   always_comb begin
      hs_fall = stb_q & hs_p & ~hs_s;
      vs_fall = stb_q & vs_p & ~vs_s;
      h_bad   = hs_fall & (hc_q != H_LAST);
      v_bad   = vs_fall & (vc_q != V_LAST);

      hc_d = hc_q;
      if (stb_q) begin
         if (hs_fall)              hc_d = '0;
         else if (hc_q != CNT_MAX) hc_d = hc_q + 10'd1;
      end

      vc_d = vc_q;
      if (vs_fall)                          vc_d = '0;
      else if (hs_fall && vc_q != CNT_MAX)  vc_d = vc_q + 10'd1;
   end

   always_comb begin
      state_d    = state_q;
      line_bad_d = line_bad_q;
      err_d      = err_q;
      case (state_q)
         ST_SEARCH: begin
            if (vs_fall) begin
               state_d    = ST_MEASURE;
               line_bad_d = 1'b0;
            end
         end
         ST_MEASURE: begin
            if (h_bad) line_bad_d = 1'b1;
            if (vs_fall) begin
               if (!line_bad_q && !h_bad && !v_bad) state_d = ST_LOCKED;
               line_bad_d = 1'b0;
            end
         end
         ST_LOCKED: begin
            if (h_bad || v_bad) begin
               err_d   = 1'b1;
               state_d = ST_SEARCH;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   // The strobe that drops lock produces no pixel.
   always_comb begin
      pix_hit    = stb_q && (state_q == ST_LOCKED) && (state_d == ST_LOCKED) &&
                   (hc_d >= H_LO) && (hc_d <= H_END) && (vc_d >= V_LO) && (vc_d <= V_END);
      line_last  = pix_hit && (hc_d == H_END);
      frame_last = line_last && (vc_d == V_END);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         hs_s        <= 1'b1;
         vs_s        <= 1'b1;
         hs_p        <= 1'b1;
         vs_p        <= 1'b1;
         rgb_s       <= '0;
         stb_q       <= 1'b0;
         hc_q        <= '0;
         vc_q        <= '0;
         state_q     <= ST_SEARCH;
         line_bad_q  <= 1'b0;
         err_q       <= 1'b0;
         locked_q    <= 1'b0;
         pix_valid_q <= 1'b0;
         line_end_q  <= 1'b0;
         frame_end_q <= 1'b0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
         pix_data_q  <= '0;
      end else begin
         if (vid.PCK_EN) begin
            hs_s  <= vid.HS;
            vs_s  <= vid.VS;
            hs_p  <= hs_s;
            vs_p  <= vs_s;
            rgb_s <= {vid.R, vid.G, vid.B};
         end
         stb_q       <= vid.PCK_EN;
         hc_q        <= hc_d;
         vc_q        <= vc_d;
         state_q     <= state_d;
         line_bad_q  <= line_bad_d;
         err_q       <= err_d;
         locked_q    <= (state_d == ST_LOCKED);
         pix_valid_q <= pix_hit;
         line_end_q  <= line_last;
         frame_end_q <= frame_last;
         if (pix_hit) begin
            pix_x_q    <= hc_d - H_LO;
            pix_y_q    <= vc_d - V_LO;
            pix_data_q <= rgb_s;
         end
      end
   end

   assign vid.PIX_VALID = pix_valid_q;
   assign vid.PIX_X     = pix_x_q;
   assign vid.PIX_Y     = pix_y_q;
   assign vid.PIX_DATA  = pix_data_q;
   assign vid.LINE_END  = line_end_q;
   assign vid.FRAME_END = frame_end_q;
   assign vid.LOCKED    = locked_q;
   assign vid.ERR       = err_q;

`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] crc_q, crc_next, frame_crc_q;

   function automatic logic [15:0] crc_fold(input logic [15:0] seed, input logic [17:0] data);
      logic [15:0] c;
      logic        fb;
      c = seed;
      for (int i = 17; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   assign crc_next = crc_fold(crc_q, rgb_s);

   // Running CRC reseeds whenever unlocked so a partial frame never leaks into the next.
   always_ff @(posedge CLK) begin
      if (RST) begin
         crc_q       <= 16'hFFFF;
         frame_crc_q <= 16'h0000;
      end else if (state_q != ST_LOCKED) begin
         crc_q <= 16'hFFFF;
      end else if (pix_hit) begin
         if (frame_last) begin
            frame_crc_q <= crc_next;
            crc_q       <= 16'hFFFF;
         end else begin
            crc_q <= crc_next;
         end
      end
   end

   assign vid.FRAME_CRC = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced 40x20 raster, PCK_EN every 4th CLK.
module tb_vga_capture;
   localparam int CP  = 10;
   localparam int HT  = 40;
   localparam int VT  = 20;
   localparam int HS0 = 8;
   localparam int VS0 = 3;
   localparam int HW  = 24;
   localparam int VW  = 12;
   localparam int HSW = 4;
   localparam int VSW = 2;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   vga_capture_if vid();

   vga_capture #(
      .HTOTAL(HT), .VTOTAL(VT), .HSTART(HS0), .VSTART(VS0), .HWIDTH(HW), .VWIDTH(VW)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .vid(vid)
   );

   always #(CP / 2) CLK = ~CLK;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [17:0] d;
      logic        le;
      logic        fe;
      time         t;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        m;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_pix = 0;
   int          short_line = -1;
   int          pat = 0;
   bit          exp_on = 1'b0;
   logic [15:0] mcrc = 16'hFFFF;
   logic [15:0] mframe_crc = 16'h0000;
   bit          first_seen = 1'b0;
   logic [9:0]  first_x, first_y;
   logic [17:0] fe_data = '0;
   logic        fe_le = 1'b0;
   logic [15:0] fe_crc = '0;
   logic [37:0] prev_out = '0;
   logic        rst_prev = 1'b1;

   function automatic logic [17:0] colour(input int l, input int p);
      if (pat == 2) return 18'h0;
      if (pat == 3) return (l == VS0 + 1 && p == HS0 + 2) ? 18'h00001 : 18'h0;
      if (pat == 0 && l == VS0 + VW - 1 && p == HS0 + HW - 1) return 18'h3F015;
      return {6'(p * 3 + l + pat * 7), 6'(l * 5 + p), 6'(p ^ l)};
   endfunction

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [17:0] d);
      int acc;
      acc = int'(c);
      for (int i = 17; i >= 0; i--) begin
         acc = acc << 1;
         if (((acc >> 16) & 1) != int'(d[i])) acc = acc ^ 'h1021;
         acc = acc & 'hFFFF;
      end
      return 16'(acc);
   endfunction

   // One strobe at raster (line l, position p); position 0 of each line is the HS fall.
   task automatic send_px(input int l, input int p);
      logic [17:0] c;
      exp_t        e;
      time         te;
      c = colour(l, p);
      @(posedge CLK);
      te = $time;
      #1;
      vid.PCK_EN = 1'b1;
      vid.HS = (p < HSW) ? 1'b0 : 1'b1;
      vid.VS = (l < VSW) ? 1'b0 : 1'b1;
      {vid.R, vid.G, vid.B} = c;
      if (exp_on && p >= HS0 && p < HS0 + HW && l >= VS0 && l < VS0 + VW) begin
         e.x  = 10'(p - HS0);
         e.y  = 10'(l - VS0);
         e.d  = c;
         e.le = (p - HS0 == HW - 1);
         e.fe = e.le && (l - VS0 == VW - 1);
         e.t  = te + 2 * CP + CP / 2;
         exp_q.push_back(e);
         if (e.x == 0 && e.y == 0) mcrc = 16'hFFFF;
         mcrc = crc_model(mcrc, c);
         if (e.fe) mframe_crc = mcrc;
      end
      @(posedge CLK);
      #1 vid.PCK_EN = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
   endtask

   task automatic send_span(input int l0, input int p0, input int l1, input int p1);
      int l, p;
      l = l0;
      p = p0;
      while (l < l1 || (l == l1 && p < p1)) begin
         send_px(l, p);
         p++;
         if (p >= ((l == short_line) ? HT - 1 : HT)) begin
            p = 0;
            l++;
         end
      end
   endtask

   always @(negedge CLK) begin
      if (vid.PIX_VALID === 1'b1) begin
         n_pix++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pix_unexpected: got x=%0d y=%0d at %0t, required no pixel",
                     vid.PIX_X, vid.PIX_Y, $time);
         end else begin
            m = exp_q.pop_front();
            if (vid.PIX_X !== m.x || vid.PIX_Y !== m.y || vid.PIX_DATA !== m.d ||
                vid.LINE_END !== m.le || vid.FRAME_END !== m.fe || $time != m.t) begin
               n_fail++;
               $display("FAIL pix_match: got x=%0d y=%0d d=%h le=%b fe=%b t=%0t, required x=%0d y=%0d d=%h le=%b fe=%b t=%0t",
                        vid.PIX_X, vid.PIX_Y, vid.PIX_DATA, vid.LINE_END, vid.FRAME_END, $time,
                        m.x, m.y, m.d, m.le, m.fe, m.t);
            end
         end
         if (!first_seen) begin
            first_seen = 1'b1;
            first_x = vid.PIX_X;
            first_y = vid.PIX_Y;
         end
         if (vid.FRAME_END === 1'b1) begin
            fe_data = vid.PIX_DATA;
            fe_le   = vid.LINE_END;
`ifdef VGA_CAPTURE_CRC_EN
            fe_crc  = vid.FRAME_CRC;
`endif
         end
      end else if (!RST && !rst_prev) begin
         n_checks++;
         if ({vid.PIX_X, vid.PIX_Y, vid.PIX_DATA} !== prev_out ||
             vid.LINE_END !== 1'b0 || vid.FRAME_END !== 1'b0) begin
            n_fail++;
            $display("FAIL pix_hold: got %h le=%b fe=%b at %0t, required %h le=0 fe=0",
                     {vid.PIX_X, vid.PIX_Y, vid.PIX_DATA}, vid.LINE_END, vid.FRAME_END,
                     $time, prev_out);
         end
      end
      prev_out = {vid.PIX_X, vid.PIX_Y, vid.PIX_DATA};
      rst_prev = RST;
   end

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) begin
         @(posedge CLK);
         #1 vid.PCK_EN = 1'b1;
         vid.HS = 1'b0;
         vid.VS = 1'b0;
         @(posedge CLK);
         #1 vid.PCK_EN = 1'b0;
      end
      @(posedge CLK);
      #1;
      n_checks++;
      if ({vid.PIX_VALID, vid.LINE_END, vid.FRAME_END} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_pulses: got %b, required 000",
                  {vid.PIX_VALID, vid.LINE_END, vid.FRAME_END});
      end
      n_checks++;
      if (vid.LOCKED !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_locked: got %b, required 0", vid.LOCKED);
      end
      n_checks++;
      if (vid.ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got %b, required 0", vid.ERR);
      end
      n_checks++;
      if (vid.PIX_X !== 10'd0 || vid.PIX_Y !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_xy: got %0d,%0d, required 0,0", vid.PIX_X, vid.PIX_Y);
      end
      n_checks++;
      if (vid.PIX_DATA !== 18'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h, required 0", vid.PIX_DATA);
      end
`ifdef VGA_CAPTURE_CRC_EN
      n_checks++;
      if (vid.FRAME_CRC !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_crc: got %h, required 0000", vid.FRAME_CRC);
      end
`endif
      RST = 1'b0;
      vid.HS = 1'b1;
      vid.VS = 1'b1;
   endtask

   task automatic test_lock();
      int base;
      exp_on = 1'b0;
      pat = 0;
      send_span(0, 0, VT, 0);
      n_checks++;
      if (vid.LOCKED !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_early: got %b, required 0", vid.LOCKED);
      end
      send_px(0, 0);
      n_checks++;
      if (vid.LOCKED !== 1'b1 || vid.ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_rise: got locked=%b err=%b, required 1 0", vid.LOCKED, vid.ERR);
      end
      exp_on = 1'b1;
      base = n_pix;
      send_span(0, 1, VT, 0);
      n_checks++;
      if (n_pix - base != HW * VW) begin
         n_fail++;
         $display("FAIL lock_count: got %0d, required %0d", n_pix - base, HW * VW);
      end
      n_checks++;
      if (!first_seen || first_x !== 10'd0 || first_y !== 10'd0) begin
         n_fail++;
         $display("FAIL lock_first: got %0d,%0d seen=%b, required 0,0", first_x, first_y,
                  first_seen);
      end
      n_checks++;
      if (fe_data !== 18'h3F015 || fe_le !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_last_px: got d=%h le=%b, required 3f015 1", fe_data, fe_le);
      end
   endtask

   task automatic test_stall();
      int base;
      pat = 1;
      base = n_pix;
      send_span(0, 0, VS0 + 4, HS0 + 5);
      repeat (100) @(posedge CLK);
      #1;
      n_checks++;
      if (vid.PIX_X !== 10'd4 || vid.PIX_Y !== 10'd4 || vid.LOCKED !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_hold: got x=%0d y=%0d locked=%b, required 4 4 1",
                  vid.PIX_X, vid.PIX_Y, vid.LOCKED);
      end
      send_span(VS0 + 4, HS0 + 5, VT, 0);
      n_checks++;
      if (n_pix - base != HW * VW) begin
         n_fail++;
         $display("FAIL stall_count: got %0d, required %0d", n_pix - base, HW * VW);
      end
   endtask

   task automatic test_error();
      int base;
      pat = 0;
      base = n_pix;
      short_line = VS0 + 2;
      send_span(0, 0, VS0 + 3, 0);
      exp_on = 1'b0;
      send_px(VS0 + 3, 0);
      n_checks++;
      if (vid.ERR !== 1'b1 || vid.LOCKED !== 1'b0) begin
         n_fail++;
         $display("FAIL err_detect: got err=%b locked=%b, required 1 0", vid.ERR, vid.LOCKED);
      end
      send_span(VS0 + 3, 1, VT, 0);
      short_line = -1;
      n_checks++;
      if (n_pix - base != 3 * HW) begin
         n_fail++;
         $display("FAIL err_partial_count: got %0d, required %0d", n_pix - base, 3 * HW);
      end
      send_span(0, 0, VT, 0);
      n_checks++;
      if (vid.LOCKED !== 1'b0) begin
         n_fail++;
         $display("FAIL err_measure: got %b, required 0", vid.LOCKED);
      end
      send_px(0, 0);
      n_checks++;
      if (vid.LOCKED !== 1'b1 || vid.ERR !== 1'b1) begin
         n_fail++;
         $display("FAIL err_relock: got locked=%b err=%b, required 1 1", vid.LOCKED, vid.ERR);
      end
      exp_on = 1'b1;
      base = n_pix;
      send_span(0, 1, VT, 0);
      n_checks++;
      if (n_pix - base != HW * VW) begin
         n_fail++;
         $display("FAIL err_relock_count: got %0d, required %0d", n_pix - base, HW * VW);
      end
   endtask

   task automatic test_rst_mid();
      send_span(0, 0, VS0 + 5, HS0 + 11);
      @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK);
      #1;
      n_checks++;
      if ({vid.PIX_VALID, vid.LINE_END, vid.FRAME_END, vid.LOCKED, vid.ERR} !== 5'b0) begin
         n_fail++;
         $display("FAIL rst_mid_flags: got %b, required 00000",
                  {vid.PIX_VALID, vid.LINE_END, vid.FRAME_END, vid.LOCKED, vid.ERR});
      end
      n_checks++;
      if ({vid.PIX_X, vid.PIX_Y, vid.PIX_DATA} !== 38'd0) begin
         n_fail++;
         $display("FAIL rst_mid_pix: got %h, required 0", {vid.PIX_X, vid.PIX_Y, vid.PIX_DATA});
      end
      RST = 1'b0;
      exp_on = 1'b0;
      send_span(VS0 + 5, HS0 + 11, VT, 0);
      send_span(0, 0, VT, 0);
      n_checks++;
      if (vid.LOCKED !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_measure: got %b, required 0", vid.LOCKED);
      end
      send_px(0, 0);
      n_checks++;
      if (vid.LOCKED !== 1'b1 || vid.ERR !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_relock: got locked=%b err=%b, required 1 0", vid.LOCKED, vid.ERR);
      end
      exp_on = 1'b1;
   endtask

   task automatic test_crc();
      int base;
      logic [15:0] c0;
      pat = 2;
      base = n_pix;
      send_span(0, 1, VT, 0);
      n_checks++;
      if (n_pix - base != HW * VW) begin
         n_fail++;
         $display("FAIL crc_zero_count: got %0d, required %0d", n_pix - base, HW * VW);
      end
      c0 = mframe_crc;
`ifdef VGA_CAPTURE_CRC_EN
      n_checks++;
      if (fe_crc !== mframe_crc) begin
         n_fail++;
         $display("FAIL crc_zero: got %h, required %h", fe_crc, mframe_crc);
      end
`endif
      pat = 3;
      send_px(0, 0);
`ifdef VGA_CAPTURE_CRC_EN
      n_checks++;
      if (vid.FRAME_CRC !== c0) begin
         n_fail++;
         $display("FAIL crc_hold: got %h, required %h", vid.FRAME_CRC, c0);
      end
`endif
      send_span(0, 1, VT, 0);
`ifdef VGA_CAPTURE_CRC_EN
      n_checks++;
      if (fe_crc !== mframe_crc || fe_crc === c0) begin
         n_fail++;
         $display("FAIL crc_flip: got %h, required %h (differs from %h)", fe_crc, mframe_crc, c0);
      end
`endif
   endtask

   initial begin
      #(CP * 80000);
      $display("FAIL watchdog: simulation exceeded %0d cycles", 80000);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vid.PCK_EN = 1'b0;
      vid.HS = 1'b1;
      vid.VS = 1'b1;
      vid.R = '0;
      vid.G = '0;
      vid.B = '0;
      test_reset();
      test_lock();
      test_stall();
      test_error();
      test_rst_mid();
      test_crc();
      repeat (5) @(posedge CLK);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
